quat_inverse: RTL and testbench
===============================

Name: quat_inverse

Overview:
- Sequential fixed-point quaternion inverse unit: q^-1 = conj(q) / |q|^2.
- Companion to the quaternion multiplier: it supplies the reciprocal operand so that quaternion division becomes a multiply.
- Shares one 16x16 signed multiplier across 4 cycles to build the norm, then uses one restoring divider (1 quotient bit/cycle) for all four components.
- Input and output use valid/ready handshakes.

Parameters:
- FRAC, 24, fractional bits of the output. Legal range 1..30. Output r_i = trunc(conj_i * 2^FRAC / N).

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand valid
- in_ready  out  1  high only in IDLE
- a0,a1,a2,a3  in  16  signed quaternion components, integer scale
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- r0,r1,r2,r3  out  32  signed inverse components, Q(31-FRAC).FRAC
- div_zero  out  1  input was the zero quaternion; qualified by out_valid

Behaviour:
- Reset:
  - state goes to IDLE.
  - in_ready=1; out_valid=0; r0..r3=0; div_zero=0.
  - All internal accumulators and counters are cleared.
  - Reset asserted mid-operation aborts the operation immediately; no partial result is ever presented.
- FSM states: IDLE, SQUARE, DIV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge E0: capture a0..a3 and clear N. Next state is SQUARE.
- SQUARE (4 cycles, E1..E4):
  - Each cycle, square one captured component in order a0,a1,a2,a3.
  - Accumulate into a 33-bit unsigned N. Max N = 4*2^30 = 2^32, which fits.
  - After E4: if N==0, go to DONE with r0..r3=0 and div_zero=1. Otherwise go to DIV.
- DIV (4 x (FRAC+16) cycles):
  - Components are processed in order 0,1,2,3.
  - Numerator magnitude = |c_i| << FRAC, FRAC+16 bits wide, where c_0=a0 and c_i=-a_i for i=1..3.
  - |-32768| = 32768 must be handled as an unsigned magnitude.
  - Restoring division, MSB first: 34-bit partial remainder, one quotient bit per cycle.
  - Sign is reapplied at the end of each component. Rounding is truncation toward zero.
  - Quotient magnitude <= 2^FRAC, because N >= c_i^2. No saturation is needed, and the result fits 32 bits for FRAC <= 30.
  - Each finished component is written to its r_i register.
- DONE:
  - out_valid=1. r0..r3 and div_zero are held stable while out_ready=0.
  - On out_valid&out_ready: out_valid drops and the FSM returns to IDLE.
  - in_ready rises one cycle after the output handshake; inputs are never accepted in the same cycle as output acceptance.
- Latency, measured from the accepting edge E0 to out_valid high:
  - Nonzero input: L = 5 + 4*(FRAC+16). With FRAC=24, L = 165 cycles.
  - Zero input: 5 cycles.
- in_valid outside IDLE is ignored, and the a_i inputs are don't-care. The captured operands are never re-sampled mid-operation.
- r_i registers keep their last result until overwritten by the next operation. They are returned to 0 only by reset or by a zero-input operation.

Test Plan:
- Identity: a=(1,0,0,0) -> N=1; after 165 cycles r0=16777216, r1=r2=r3=0, div_zero=0.
- Uniform: a=(1,1,1,1) -> N=4; r0=4194304, r1=r2=r3=-4194304.
- Truncation: a=(3,0,4,0) -> N=25; r0=2013265, r1=0, r2=-2684354, r3=0. Also check the round-trip product through the multiplier is approximately 2^FRAC real part.
- Extreme: a=(-32768,0,0,0) -> N=2^30; r0=-512. Separately, a=(0,-32768,0,0) -> r1=+512.
- Zero and backpressure: a=(0,0,0,0) -> out_valid 5 cycles after accept, div_zero=1, r=0. Hold out_ready=0 for 10 cycles with in_valid=1 -> in_ready stays 0 and outputs are stable. Release out_ready -> in_ready=1 the next cycle.
- Reset mid-DIV: assert rst 50 cycles after accept -> out_valid=0, r=0, in_ready=1 immediately. A new operation a=(1,1,1,1) then completes correctly in 165 cycles.

Source files
------------

// File: rtl/quat_inverse_if.sv
// ---------------------------------------------------------------------------
// quat_inverse_if
// Handshake and data bundle for the quaternion inverse unit.
//   in_valid / in_ready   : operand handshake (producer -> unit)
//   a0..a3                : signed 16-bit quaternion components, integer scale
//   out_valid / out_ready : result handshake (unit -> consumer)
//   r0..r3                : signed 32-bit inverse components, Q(31-FRAC).FRAC
//   div_zero              : operand was the zero quaternion (with out_valid)
// master = the side feeding operands and taking results (bench / system),
// slave  = the inverse unit itself.
// ---------------------------------------------------------------------------
interface quat_inverse_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] a0;
  logic signed [15:0] a1;
  logic signed [15:0] a2;
  logic signed [15:0] a3;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] r0;
  logic signed [31:0] r1;
  logic signed [31:0] r2;
  logic signed [31:0] r3;
  logic               div_zero;

  modport master (
    output in_valid, a0, a1, a2, a3, out_ready,
    input  in_ready, out_valid, r0, r1, r2, r3, div_zero
  );

  modport slave (
    input  in_valid, a0, a1, a2, a3, out_ready,
    output in_ready, out_valid, r0, r1, r2, r3, div_zero
  );
endinterface

// File: rtl/quat_inverse.sv
// ---------------------------------------------------------------------------
// quat_inverse
// Sequential fixed-point quaternion inverse: q^-1 = conj(q) / |q|^2.
// The norm N is built with one shared 16x16 signed multiplier over four
// cycles; a single restoring divider (one quotient bit per cycle) then
// produces the four components r_i = trunc(c_i * 2^FRAC / N), where
// c_0 = a0 and c_i = -a_i for i = 1..3.
//
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-high reset, aborts any operation in flight
//   bus : quat_inverse_if.slave (operand/result handshakes and data)
//
// Parameter:
//   FRAC : fractional bits of the result, 1..30
// ---------------------------------------------------------------------------
module quat_inverse #(
  parameter int FRAC = 24
) (
  input  logic          clk,
  input  logic          rst,
  quat_inverse_if.slave bus
);

  // Numerator |c_i| << FRAC needs 16 + FRAC bits (|c_i| can be 32768).
  localparam int NUMW = FRAC + 16;
  localparam int CW   = $clog2(NUMW);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    DIV    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic signed [15:0] r_a [4];      // captured operands
  logic [32:0]        r_norm;       // sum of squares, up to 2^32
  logic [1:0]         r_sq_idx;     // component being squared
  logic [1:0]         r_comp;       // component being divided
  logic [CW-1:0]      r_bit;        // quotient bit counter within a component
  logic [32:0]        r_rem;        // partial remainder, always < N
  logic [NUMW-1:0]    r_num;        // numerator shift register, MSB first
  logic [NUMW-1:0]    r_quot;       // quotient magnitude shift register
  logic               r_neg;        // sign of the component being divided
  logic signed [31:0] r_res [4];    // result registers
  logic               r_div_zero;
  logic               r_out_valid;

  // -------------------------------------------------------------------------
  // Per-component numerator magnitude and result sign.
  // The magnitude is taken as an unsigned 16-bit value so that -32768 maps
  // to 32768 without overflow. Negating a_i (conjugate) leaves the
  // magnitude unchanged, so only the sign differs between c_0 and c_1..3.
  // -------------------------------------------------------------------------
  logic [NUMW-1:0] w_num_init [4];
  logic            w_neg_init [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_comp
    logic [15:0] w_abs;
    assign w_abs          = r_a[gi][15] ? (~r_a[gi] + 16'd1) : r_a[gi];
    assign w_num_init[gi] = {w_abs, {FRAC{1'b0}}};
    if (gi == 0) begin : g_real
      assign w_neg_init[gi] = r_a[gi][15];
    end else begin : g_imag
      // c_i = -a_i is negative exactly when a_i is strictly positive.
      assign w_neg_init[gi] = ~r_a[gi][15] && (r_a[gi] != 16'sd0);
    end
  end

  // -------------------------------------------------------------------------
  // Norm accumulation: one shared multiplier, one square per cycle.
  // -------------------------------------------------------------------------
  logic signed [31:0] w_sq;
  logic [32:0]        w_norm_acc;
  logic               w_sq_last;

  assign w_sq       = r_a[r_sq_idx] * r_a[r_sq_idx];
  assign w_norm_acc = r_norm + {1'b0, w_sq};
  assign w_sq_last  = (r_sq_idx == 2'd3);

  // -------------------------------------------------------------------------
  // Restoring divider step. trial < 2N <= 2^33, so its top bit is always 0
  // and the sign of (trial - N) in 34 bits decides the quotient bit.
  // -------------------------------------------------------------------------
  logic [33:0]     w_trial;
  logic [33:0]     w_diff;
  logic            w_ge;
  logic [32:0]     w_rem_next;
  logic [NUMW-1:0] w_quot_next;
  logic [31:0]     w_qmag;
  logic [31:0]     w_res;
  logic            w_bit_last;
  logic [1:0]      w_comp_next;

  assign w_trial     = {r_rem, r_num[NUMW-1]};
  assign w_diff      = w_trial - {1'b0, r_norm};
  assign w_ge        = ~w_diff[33];
  assign w_rem_next  = w_ge ? w_diff[32:0] : w_trial[32:0];
  assign w_quot_next = {r_quot[NUMW-2:0], w_ge};
  // Quotient magnitude never exceeds 2^FRAC, so the low 32 bits hold it.
  assign w_qmag      = 32'(w_quot_next);
  assign w_res       = r_neg ? (~w_qmag + 32'd1) : w_qmag;
  assign w_bit_last  = (r_bit == CW'(NUMW - 1));
  assign w_comp_next = r_comp + 2'd1;

  logic w_out_take;
  assign w_out_take = r_out_valid && bus.out_ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_state_next = SQUARE;
        end
      end
      SQUARE: begin
        if (w_sq_last) begin
          w_state_next = (w_norm_acc == 33'd0) ? DONE : DIV;
        end
      end
      DIV: begin
        if (w_bit_last && (r_comp == 2'd3)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (w_out_take) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_a[i]   <= '0;
        r_res[i] <= '0;
      end
      r_norm      <= '0;
      r_sq_idx    <= '0;
      r_comp      <= '0;
      r_bit       <= '0;
      r_rem       <= '0;
      r_num       <= '0;
      r_quot      <= '0;
      r_neg       <= 1'b0;
      r_div_zero  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a[0]     <= bus.a0;
            r_a[1]     <= bus.a1;
            r_a[2]     <= bus.a2;
            r_a[3]     <= bus.a3;
            r_norm     <= '0;
            r_sq_idx   <= '0;
            r_div_zero <= 1'b0;
          end
        end

        SQUARE: begin
          r_norm   <= w_norm_acc;
          r_sq_idx <= r_sq_idx + 2'd1;
          if (w_sq_last) begin
            if (w_norm_acc == 33'd0) begin
              r_div_zero <= 1'b1;
              for (int i = 0; i < 4; i++) begin
                r_res[i] <= '0;
              end
            end else begin
              r_comp <= '0;
              r_bit  <= '0;
              r_rem  <= '0;
              r_quot <= '0;
              r_num  <= w_num_init[0];
              r_neg  <= w_neg_init[0];
            end
          end
        end

        DIV: begin
          r_rem  <= w_rem_next;
          r_num  <= r_num << 1;
          r_quot <= w_quot_next;
          r_bit  <= r_bit + CW'(1);
          if (w_bit_last) begin
            // Component finished: publish it and load the next numerator.
            r_res[r_comp] <= w_res;
            r_comp        <= w_comp_next;
            r_bit         <= '0;
            r_rem         <= '0;
            r_quot        <= '0;
            r_num         <= w_num_init[w_comp_next];
            r_neg         <= w_neg_init[w_comp_next];
          end
        end

        DONE: begin
          // out_valid rises on the first DONE cycle and stays until taken.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end

        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.r0        = r_res[0];
  assign bus.r1        = r_res[1];
  assign bus.r2        = r_res[2];
  assign bus.r3        = r_res[3];
  assign bus.div_zero  = r_div_zero;

endmodule

// File: tb/tb_quat_inverse.sv
// ---------------------------------------------------------------------------
// tb_quat_inverse
// Self-checking bench for quat_inverse. Expected results come from a plain
// arithmetic model: N = sum a_i^2, r_i = trunc(c_i * 2^FRAC / N).
// ---------------------------------------------------------------------------
module tb_quat_inverse;
  localparam int FRAC = 24;
  localparam int NUMW = FRAC + 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  quat_inverse_if bus();

  quat_inverse #(.FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint get_r(input int i);
    case (i)
      0:       return longint'(bus.r0);
      1:       return longint'(bus.r1);
      2:       return longint'(bus.r2);
      default: return longint'(bus.r3);
    endcase
  endfunction

  function automatic int rnd16();
    int v;
    case ($urandom_range(0, 4))
      0:       v = int'($urandom_range(0, 6)) - 3;
      1:       v = ($urandom_range(0, 1) != 0) ? -32768 : 32767;
      2:       v = int'($urandom_range(0, 200)) - 100;
      default: v = int'($urandom_range(0, 65535)) - 32768;
    endcase
    return v;
  endfunction

  // One complete operation: accept, latency, results, optional backpressure,
  // output handshake.
  task automatic run_op(input int x0, input int x1, input int x2, input int x3,
                        input bit hold);
    longint a [4];
    longint c [4];
    longint exp_r [4];
    longint n;
    longint re;
    longint tol;
    longint err;
    int     lat;
    int     exp_lat;
    bit     zero;

    a[0] = x0; a[1] = x1; a[2] = x2; a[3] = x3;
    n = 0;
    for (int i = 0; i < 4; i++) n += a[i] * a[i];
    zero = (n == 0);
    for (int i = 0; i < 4; i++) begin
      c[i]     = (i == 0) ? a[i] : -a[i];
      exp_r[i] = zero ? 0 : (c[i] * (64'sd1 <<< FRAC)) / n;
    end
    exp_lat = zero ? 5 : 5 + 4 * NUMW;

    lat = 0;
    while (!bus.in_ready && lat < 1000) begin
      @(posedge clk); #1; lat++;
    end
    check("in_ready_idle", longint'(bus.in_ready), 1);

    bus.in_valid = 1'b1;
    bus.a0 = 16'(x0); bus.a1 = 16'(x1); bus.a2 = 16'(x2); bus.a3 = 16'(x3);
    @(posedge clk); #1;
    // Operands are don't-care once captured; scramble them.
    bus.in_valid = 1'b0;
    bus.a0 = 16'($urandom); bus.a1 = 16'($urandom);
    bus.a2 = 16'($urandom); bus.a3 = 16'($urandom);
    check("in_ready_busy", longint'(bus.in_ready), 0);

    lat = 0;
    while (!bus.out_valid && lat < 400) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", lat, exp_lat);
    for (int i = 0; i < 4; i++) check($sformatf("r%0d", i), get_r(i), exp_r[i]);
    check("div_zero", longint'(bus.div_zero), longint'(zero));

    if (!zero) begin
      // Real part of q * q^-1 should be close to 2^FRAC.
      re  = a[0] * get_r(0) - a[1] * get_r(1) - a[2] * get_r(2) - a[3] * get_r(3);
      tol = 0;
      for (int i = 0; i < 4; i++) tol += (a[i] < 0) ? -a[i] : a[i];
      err = re - (64'sd1 <<< FRAC);
      if (err < 0) err = -err;
      check("roundtrip_ok", longint'(err <= tol), 1);
    end

    if (hold) begin
      bus.in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        check("hold_in_ready", longint'(bus.in_ready), 0);
        check("hold_out_valid", longint'(bus.out_valid), 1);
        for (int i = 0; i < 4; i++) check($sformatf("hold_r%0d", i), get_r(i), exp_r[i]);
        check("hold_div_zero", longint'(bus.div_zero), longint'(zero));
      end
    end

    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("in_ready_after", longint'(bus.in_ready), 1);
    check("out_valid_after", longint'(bus.out_valid), 0);
    $display("op a=(%0d,%0d,%0d,%0d) N=%0d r=(%0d,%0d,%0d,%0d) dz=%0d",
             x0, x1, x2, x3, n, get_r(0), get_r(1), get_r(2), get_r(3), bus.div_zero);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a0 = '0; bus.a1 = '0; bus.a2 = '0; bus.a3 = '0;

    #2;
    check("rst_in_ready", longint'(bus.in_ready), 1);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_div_zero", longint'(bus.div_zero), 0);
    for (int i = 0; i < 4; i++) check($sformatf("rst_r%0d", i), get_r(i), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1, 0, 0, 0, 1'b0);
    run_op(1, 1, 1, 1, 1'b0);
    run_op(3, 0, 4, 0, 1'b0);
    run_op(-32768, 0, 0, 0, 1'b0);
    run_op(0, -32768, 0, 0, 1'b0);
    run_op(0, 0, 0, 0, 1'b1);
    run_op(-32768, -32768, -32768, -32768, 1'b0);
    run_op(7, -5, 3, -2, 1'b1);

    // Reset in the middle of the division phase (component 0 already written).
    bus.in_valid = 1'b1;
    bus.a0 = 16'sd5; bus.a1 = 16'sd6; bus.a2 = 16'sd7; bus.a3 = 16'sd8;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (49) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", longint'(bus.out_valid), 0);
    check("midrst_in_ready", longint'(bus.in_ready), 1);
    check("midrst_div_zero", longint'(bus.div_zero), 0);
    for (int i = 0; i < 4; i++) check($sformatf("midrst_r%0d", i), get_r(i), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(1, 1, 1, 1, 1'b0);

    for (int t = 0; t < 20; t++) begin
      run_op(rnd16(), rnd16(), rnd16(), rnd16(), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
